regfile_rename: RTL and testbench

- Parametrised successor to the architectural register file for the out-of-order core.
- Each architectural register holds its value plus a rename status entry: a busy bit and a ROB tag naming the in-flight producer.
- Sits between decode/dispatch, which reads operands and claims destinations at issue, and ROB commit, which writes results and releases claims.
- Adds N read ports, producer tracking, and a flush on misprediction.

---
 rtl/rv_pkg.sv | 14 +
 rtl/regfile_rename_rdport.sv | 36 +++
 rtl/regfile_rename.sv | 76 +++++++
 tb/tb_regfile_rename.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared constants, address-width helper and rename status type for regfile_rename
package rv_pkg;
  localparam int XLEN_DEF  = 32;
  localparam int NREG_DEF  = 32;
  localparam int TAG_W_DEF = 4;
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int AW_DEF = addr_w(NREG_DEF);
  typedef struct packed {
    logic                 busy;
    logic [TAG_W_DEF-1:0] tag;
  } status_t;
endpackage

// File: rtl/regfile_rename_rdport.sv
// regfile_rename_rdport: one combinational read port with x0 zeroing; commit forwarding
// when REGFILE_RENAME_BYPASS_EN is defined
module regfile_rename_rdport
  import rv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int AW    = addr_w(NREG)
) (
  input  logic [AW-1:0]    addr,
  input  logic [XLEN-1:0]  regs [NREG],
  input  logic [NREG-1:0]  busy,
  input  logic [TAG_W-1:0] tags [NREG],
  input  logic             byp,
  input  logic [AW-1:0]    cmt_rd,
  input  logic [TAG_W-1:0] cmt_tag,
  input  logic [XLEN-1:0]  cmt_data,
  output logic [XLEN-1:0]  rd_data,
  output logic             rd_busy,
  output logic [TAG_W-1:0] rd_tag
);
`ifdef REGFILE_RENAME_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic hit, zero;
  always_comb begin
    zero    = addr == '0;
    hit     = BYP && byp && addr == cmt_rd && cmt_rd != '0;
    rd_data = zero ? '0 : hit ? cmt_data : regs[addr];
    rd_busy = !zero && busy[addr] && !(hit && tags[addr] == cmt_tag);
    rd_tag  = zero ? '0 : tags[addr];
  end
endmodule

// File: rtl/regfile_rename.sv
// regfile_rename: architectural register file with per-register busy/ROB-tag rename status,
// NRD read ports and flush; REGFILE_RENAME_BYPASS_EN enables zero-latency commit forwarding
module regfile_rename
  import rv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int NRD   = 2,
  localparam int AW   = addr_w(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic                 iss_we,
  input  logic [AW-1:0]        iss_rd,
  input  logic [TAG_W-1:0]     iss_tag,
  input  logic                 cmt_we,
  input  logic [AW-1:0]        cmt_rd,
  input  logic [TAG_W-1:0]     cmt_tag,
  input  logic [XLEN-1:0]      cmt_data,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  output logic [NRD*TAG_W-1:0] rd_tag
);
  typedef struct packed {
    logic             busy;
    logic [TAG_W-1:0] tag;
  } stat_t;
  logic [XLEN-1:0]  regs [NREG];
  stat_t            st   [NREG];
  logic [NREG-1:0]  busy;
  logic [TAG_W-1:0] tags [NREG];
  logic             byp;
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        st[i]   <= '0;
      end
    else if (rdy) begin
      if (cmt_we && cmt_rd != '0) begin
        regs[cmt_rd] <= cmt_data;
        if (st[cmt_rd].busy && st[cmt_rd].tag == cmt_tag) st[cmt_rd].busy <= 1'b0;
      end
      // a same-cycle issue overrides the commit's release: the newer producer wins
      if (flush)
        for (int i = 0; i < NREG; i++) st[i].busy <= 1'b0;
      else if (iss_we && iss_rd != '0)
        st[iss_rd] <= '{busy: 1'b1, tag: iss_tag};
    end
  always_comb
    for (int i = 0; i < NREG; i++) begin
      busy[i] = st[i].busy;
      tags[i] = st[i].tag;
    end
  // forwarding is held off during reset so outputs stay zero
  assign byp = rdy && cmt_we && rst;
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_rename_rdport #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .AW(AW)) u_rd (
      .addr    (rd_addr[k*AW +: AW]),
      .regs    (regs),
      .busy    (busy),
      .tags    (tags),
      .byp     (byp),
      .cmt_rd  (cmt_rd),
      .cmt_tag (cmt_tag),
      .cmt_data(cmt_data),
      .rd_data (rd_data[k*XLEN +: XLEN]),
      .rd_busy (rd_busy[k]),
      .rd_tag  (rd_tag[k*TAG_W +: TAG_W])
    );
  end
endmodule

// File: tb/tb_regfile_rename.sv
// tb_regfile_rename: directed self-checking bench for regfile_rename; expectations follow
// REGFILE_RENAME_BYPASS_EN
module tb_regfile_rename;
  logic        clk, rst, rdy, flush, iss_we, cmt_we;
  logic [4:0]  iss_rd, cmt_rd, a0, a1;
  logic [3:0]  iss_tag, cmt_tag;
  logic [31:0] cmt_data;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [7:0]  rd_tag;
  int checks = 0, errors = 0;

  regfile_rename dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .iss_we(iss_we), .iss_rd(iss_rd), .iss_tag(iss_tag),
    .cmt_we(cmt_we), .cmt_rd(cmt_rd), .cmt_tag(cmt_tag), .cmt_data(cmt_data),
    .rd_addr({a1, a0}), .rd_data(rd_data), .rd_busy(rd_busy), .rd_tag(rd_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    iss_we = 1'b0;
    cmt_we = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic issue(input logic [4:0] r, input logic [3:0] t);
    iss_we = 1'b1; iss_rd = r; iss_tag = t;
  endtask

  task automatic commit(input logic [4:0] r, input logic [3:0] t, input logic [31:0] d);
    cmt_we = 1'b1; cmt_rd = r; cmt_tag = t; cmt_data = d;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; flush = 1'b0; iss_we = 1'b0; cmt_we = 1'b0;
    iss_rd = '0; iss_tag = '0; cmt_rd = '0; cmt_tag = '0; cmt_data = '0;
    a0 = 5'd5; a1 = 5'd3;
    commit(5'd5, 4'd1, 32'h123);
    #12;
    chk("rst_data0", rd_data[31:0], 32'h0);
    chk("rst_busy0", {31'b0, rd_busy[0]}, 32'h0);
    chk("rst_data1", rd_data[63:32], 32'h0);
    cmt_we = 1'b0;
    #1 rst = 1'b1;
    // reset mid-operation
    issue(5'd5, 4'd3);
    commit(5'd5, 4'd9, 32'hDEAD_BEEF);
    cyc();
    a0 = 5'd5;
    #1;
    chk("x5_data", rd_data[31:0], 32'hDEAD_BEEF);
    chk("x5_busy", {31'b0, rd_busy[0]}, 32'h1);
    chk("x5_tag", {28'b0, rd_tag[3:0]}, 32'h3);
    rst = 1'b0;
    #1;
    chk("x5_rst_data", rd_data[31:0], 32'h0);
    chk("x5_rst_busy", {31'b0, rd_busy[0]}, 32'h0);
    chk("x5_rst_tag", {28'b0, rd_tag[3:0]}, 32'h0);
    rst = 1'b1;
    // issue then commit
    a0 = 5'd7;
    issue(5'd7, 4'd2);
    cyc();
    chk("x7_iss_busy", {31'b0, rd_busy[0]}, 32'h1);
    chk("x7_iss_tag", {28'b0, rd_tag[3:0]}, 32'h2);
    commit(5'd7, 4'd2, 32'h1234);
    cyc();
    chk("x7_cmt_data", rd_data[31:0], 32'h1234);
    chk("x7_cmt_busy", {31'b0, rd_busy[0]}, 32'h0);
    // stale commit
    issue(5'd7, 4'd2);
    cyc();
    issue(5'd7, 4'd5);
    cyc();
    commit(5'd7, 4'd2, 32'hAA);
    cyc();
    chk("stale_data", rd_data[31:0], 32'hAA);
    chk("stale_busy", {31'b0, rd_busy[0]}, 32'h1);
    chk("stale_tag", {28'b0, rd_tag[3:0]}, 32'h5);
    a1 = 5'd7;
    #1;
    chk("dual_port_data", rd_data[63:32], 32'hAA);
    chk("dual_port_tag", {28'b0, rd_tag[7:4]}, 32'h5);
    // same-cycle issue/commit, then flush with issue
    a0 = 5'd9; a1 = 5'd10;
    issue(5'd9, 4'd6);
    commit(5'd9, 4'd1, 32'h55);
    cyc();
    chk("x9_data", rd_data[31:0], 32'h55);
    chk("x9_busy", {31'b0, rd_busy[0]}, 32'h1);
    chk("x9_tag", {28'b0, rd_tag[3:0]}, 32'h6);
    flush = 1'b1;
    issue(5'd10, 4'd4);
    cyc();
    chk("flush_x9_busy", {31'b0, rd_busy[0]}, 32'h0);
    chk("flush_x9_data", rd_data[31:0], 32'h55);
    chk("flush_x10_busy", {31'b0, rd_busy[1]}, 32'h0);
    a0 = 5'd7;
    #1;
    chk("flush_x7_busy", {31'b0, rd_busy[0]}, 32'h0);
    // x0 and rdy
    a0 = 5'd0;
    issue(5'd0, 4'd7);
    commit(5'd0, 4'd0, 32'hFFFF_FFFF);
    #1;
    chk("x0_same_cycle", rd_data[31:0], 32'h0);
    cyc();
    chk("x0_data", rd_data[31:0], 32'h0);
    chk("x0_busy", {31'b0, rd_busy[0]}, 32'h0);
    chk("x0_tag", {28'b0, rd_tag[3:0]}, 32'h0);
    rdy = 1'b0;
    a0 = 5'd3;
    commit(5'd3, 4'd0, 32'h77);
    issue(5'd3, 4'd1);
    #1;
    chk("rdy0_nobyp", rd_data[31:0], 32'h0);
    cyc();
    rdy = 1'b1;
    #1;
    chk("rdy0_data", rd_data[31:0], 32'h0);
    chk("rdy0_busy", {31'b0, rd_busy[0]}, 32'h0);
    // bypass window on port 1
    a1 = 5'd4;
    issue(5'd4, 4'd1);
    cyc();
    commit(5'd4, 4'd1, 32'h99);
    #1;
`ifdef REGFILE_RENAME_BYPASS_EN
    chk("byp_data", rd_data[63:32], 32'h99);
    chk("byp_busy", {31'b0, rd_busy[1]}, 32'h0);
`else
    chk("byp_data", rd_data[63:32], 32'h0);
    chk("byp_busy", {31'b0, rd_busy[1]}, 32'h1);
`endif
    cmt_tag = 4'd2;
    #1;
`ifdef REGFILE_RENAME_BYPASS_EN
    chk("byp_wrongtag_data", rd_data[63:32], 32'h99);
`else
    chk("byp_wrongtag_data", rd_data[63:32], 32'h0);
`endif
    chk("byp_wrongtag_busy", {31'b0, rd_busy[1]}, 32'h1);
    cmt_tag = 4'd1;
    cyc();
    chk("post_byp_data", rd_data[63:32], 32'h99);
    chk("post_byp_busy", {31'b0, rd_busy[1]}, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
